// File: rtl/legv8_multicycle_control_pkg.sv
// legv8_multicycle_control_pkg: shared state codes, instruction classes, alu_op encodings and opcode patterns
package legv8_multicycle_control_pkg;
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;
  typedef enum logic [3:0] {
    C_R, C_RS, C_I, C_IS, C_LOAD, C_STORE, C_CBZ, C_CBNZ, C_B, C_ILLEGAL
  } iclass_t;
  localparam logic [1:0] ALU_ADDR = 2'b00;
  localparam logic [1:0] ALU_CB   = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  // Opcode patterns; '?' bits belong to the immediate / offset fields.
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_ANDS  = 11'b11101010000;
  localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
  localparam logic [10:0] OP_SUBI  = 11'b1101000100?;
  localparam logic [10:0] OP_ANDI  = 11'b1001001000?;
  localparam logic [10:0] OP_ORRI  = 11'b1011001000?;
  localparam logic [10:0] OP_EORI  = 11'b1101001000?;
  localparam logic [10:0] OP_ADDIS = 11'b1011000100?;
  localparam logic [10:0] OP_SUBIS = 11'b1111000100?;
  localparam logic [10:0] OP_ANDIS = 11'b1111001000?;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100???;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101???;
  localparam logic [10:0] OP_B     = 11'b000101?????;
endpackage

// File: rtl/legv8_instr_class.sv
// legv8_instr_class: combinational opcode-to-instruction-class decoder
module legv8_instr_class
  import legv8_multicycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output iclass_t     iclass
);
  always_comb begin
    iclass = C_ILLEGAL;
    casez (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR: iclass = C_R;
      OP_ADDS, OP_SUBS, OP_ANDS:                               iclass = C_RS;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI:             iclass = C_I;
      OP_ADDIS, OP_SUBIS, OP_ANDIS:                            iclass = C_IS;
      OP_LDUR:                                                 iclass = C_LOAD;
      OP_STUR:                                                 iclass = C_STORE;
      OP_CBZ:                                                  iclass = C_CBZ;
      OP_CBNZ:                                                 iclass = C_CBNZ;
      OP_B:                                                    iclass = C_B;
      default:                                                 iclass = C_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/legv8_multicycle_control.sv
// legv8_multicycle_control: multicycle LEGv8 control FSM (fetch/decode/execute/mem/wb/trap)
module legv8_multicycle_control
  import legv8_multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_read,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        readreg2_control,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src,
  output logic        update_sreg,
  output logic        halted,
  output logic [1:0]  alu_op,
  output logic [2:0]  state
);
  state_t  st, nxt;
  iclass_t cls, dec;

  legv8_instr_class u_class (.opcode(opcode), .iclass(dec));

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= S_FETCH;
      cls <= C_R;
    end else begin
      st <= nxt;
      if (st == S_DECODE) cls <= dec;
    end
  end

  always_comb begin
    nxt              = st;
    imem_read        = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    readreg2_control = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_to_reg       = 1'b0;
    reg_write        = 1'b0;
    alu_src          = 1'b0;
    update_sreg      = 1'b0;
    halted           = 1'b0;
    alu_op           = ALU_ADDR;
    case (st)
      S_FETCH: begin
        imem_read = 1'b1;
        ir_write  = imem_ready;
        pc_write  = imem_ready;
        nxt       = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: nxt = (dec == C_ILLEGAL) ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        case (cls)
          C_R, C_RS, C_I, C_IS: begin
            alu_op      = ALU_FUNC;
            alu_src     = (cls == C_I) || (cls == C_IS);
            update_sreg = (cls == C_RS) || (cls == C_IS);
            nxt         = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src          = 1'b1;
            readreg2_control = (cls == C_STORE);
            nxt              = S_MEM;
          end
          C_CBZ, C_CBNZ: begin
            readreg2_control = 1'b1;
            alu_op           = ALU_CB;
            pc_write         = (cls == C_CBZ) ? zero : !zero;
            pc_src           = pc_write;
            nxt              = S_FETCH;
          end
          C_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            nxt      = S_FETCH;
          end
          default: nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls == C_LOAD);
        mem_write = (cls == C_STORE);
        nxt       = !dmem_ready ? S_MEM : (cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LOAD);
        nxt        = S_FETCH;
      end
      S_TRAP: begin
        halted = 1'b1;
        nxt    = S_TRAP;
      end
      default: nxt = S_TRAP;
    endcase
  end
endmodule

// File: doc/legv8_multicycle_control.md
LEGV8_MULTICYCLE_CONTROL -- requirements
Module: legv8_multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces FETCH state and clears registers immediately.
REQ-003 SHALL have port: opcode  input  11  instruction bits [31:21] from instruction register; valid from DECODE onward.
REQ-004 SHALL have port: zero  input  1  ALU zero flag, sampled in EXECUTE.
REQ-005 SHALL have port: imem_ready  input  1  instruction memory read complete this cycle.
REQ-006 SHALL have port: dmem_ready  input  1  data memory access complete this cycle.
REQ-007 SHALL have ports (outputs, 1 bit each): imem_read, ir_write, pc_write, pc_src (0=PC+4, 1=branch target), readreg2_control, mem_read, mem_write, mem_to_reg, reg_write, alu_src, update_sreg, halted.
REQ-008 SHALL have port: alu_op  output  2  00=address add, 01=pass/compare for CB, 10=function from opcode.
REQ-009 SHALL have port: state  output  3  current FSM state for debug.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6-7 unreachable and SHALL go to TRAP.
REQ-011 FETCH: imem_read=1; on imem_ready, ir_write=1, pc_write=1, pc_src=0 in that cycle, next=DECODE; else stay.
REQ-012 DECODE: one cycle; latch instruction class from opcode into a class register (R, RS, I, IS, LOAD, STORE, CBZ, CBNZ, B, ILLEGAL); ILLEGAL -> TRAP, else -> EXECUTE.
REQ-013 EXECUTE, R/RS: alu_src=0, alu_op=10; I/IS: alu_src=1, alu_op=10; update_sreg=1 only for RS/IS; next=WB.
REQ-014 EXECUTE, LOAD/STORE: alu_src=1, alu_op=00, readreg2_control=1 for STORE; next=MEM.
REQ-015 EXECUTE, CBZ/CBNZ: readreg2_control=1, alu_op=01; pc_write=1 with pc_src=1 iff (CBZ and zero) or (CBNZ and !zero); next=FETCH.
REQ-016 EXECUTE, B: pc_write=1, pc_src=1 unconditionally; next=FETCH.
REQ-017 MEM: LOAD asserts mem_read, STORE asserts mem_write, held until dmem_ready; on dmem_ready LOAD -> WB, STORE -> FETCH.
REQ-018 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LOAD, 0 for R/RS/I/IS; next=FETCH.
REQ-019 TRAP: halted=1, all other outputs 0; held until reset.
REQ-020 All outputs SHALL be combinational from state and class register only, except pc_write/ir_write/pc_src, which also depend on imem_ready/zero; outputs not listed for a state are 0.
REQ-021 Zero-wait latency (ready high on first request cycle): R/I 4 cycles, LOAD 5, STORE 4, CB/B 3.
REQ-022 reg_write and mem_write SHALL never assert in the same cycle; pc_write SHALL assert at most once per fetch-to-FETCH instruction pass except for taken branches (once in FETCH, once in EXECUTE).
REQ-023 imem_ready/dmem_ready asserted outside FETCH/MEM SHALL be ignored.

Reset
REQ-024 Reset asserted at any time, including mid-MEM wait, SHALL force state=FETCH, class=ILLEGAL-cleared (R), all strobes 0 except imem_read=1 while in FETCH after reset release.
REQ-025 First rising edge after reset deassertion SHALL evaluate FETCH normally.

Structure
REQ-026 Opcode macros, state codes and alu_op encodings SHALL live in the shared constants.vh header.
REQ-027 Opcode-to-class decoding SHALL be a sub-module legv8_instr_class (combinational, casex on opcode).

Verification
REQ-028 ADD (10001011000), ready=1 -> states 0,1,2,4,0; reg_write=1 only in WB, mem_to_reg=0, alu_op=10.
REQ-029 LDUR (11111000010), dmem_ready low 3 cycles -> mem_read held 4 cycles in MEM, then WB with mem_to_reg=1; total 8 cycles.
REQ-030 CBZ (10110100xxx) zero=1 -> pc_write with pc_src=1 in EXECUTE; zero=0 -> no pc_write in EXECUTE; both return to FETCH.
REQ-031 STUR (11111000000) -> mem_write in MEM, readreg2_control=1, no WB, reg_write never 1.
REQ-032 opcode 11111111111 -> TRAP after DECODE, halted=1 held 10 cycles; reset mid-TRAP and mid-MEM -> state=0 asynchronously, strobes cleared.
